// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: product = multiplicand * multiplier, one partial product per clock.
// Define SEQ_MUL_ADDEND_EN to add an addend port and compute multiplicand * multiplier + addend.
module seq_multiplier #(
   parameter int unsigned QW = 9,
   parameter int unsigned DW = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DW-1:0]    multiplicand,
   input  logic [QW-1:0]    multiplier,
`ifdef SEQ_MUL_ADDEND_EN
   input  logic [DW-1:0]    addend,
`endif
   output logic             busy,
   output logic             done,
   output logic [QW+DW-1:0] product
);

   localparam int unsigned PW = QW + DW;
   localparam int unsigned CW = (QW > 1) ? $clog2(QW) : 1;
   localparam logic [CW-1:0] CntLast = CW'(QW - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] mcand_q, mcand_d;
   logic [PW-1:0] acc_q, acc_d;
   logic [PW-1:0] product_q, product_d;
   logic [QW-1:0] mplier_q, mplier_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] acc_init;
   logic [PW-1:0] acc_sum;
   logic          accept;
   logic          last;

`ifdef SEQ_MUL_ADDEND_EN
   assign acc_init = {{QW{1'b0}}, addend};
`else
   assign acc_init = '0;
`endif

   // New operands are taken in IDLE and DONE, never while iterating.
   assign accept  = start && (state_q != StRun);
   assign last    = (state_q == StRun) && (cnt_q == CntLast);
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = start ? StRun : StIdle;
         StRun:   state_d = last ? StDone : StRun;
         StDone:  state_d = start ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q == StRun);
      done = (state_q == StDone);
   end

   always_comb begin
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      if (accept) begin
         mcand_d  = {{QW{1'b0}}, multiplicand};
         mplier_d = multiplier;
         acc_d    = acc_init;
         cnt_d    = '0;
      end else if (state_q == StRun) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         acc_d    = acc_sum;
         cnt_d    = cnt_q + 1'b1;
         // Result register only moves on the edge entering DONE.
         if (last) begin
            product_d = acc_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks for seq_multiplier; follows SEQ_MUL_ADDEND_EN like the RTL.
module tb_seq_multiplier;

   localparam int unsigned QW = 9;
   localparam int unsigned DW = 17;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [DW-1:0]    multiplicand;
   logic [QW-1:0]    multiplier;
   logic [DW-1:0]    addend;
   logic             busy;
   logic             done;
   logic [QW+DW-1:0] product;

   int checks;
   int errors;

   seq_multiplier #(
      .QW(QW),
      .DW(DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
`ifdef SEQ_MUL_ADDEND_EN
      .addend       (addend),
`endif
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until done is seen, counting edges and busy cycles; bounded.
   task automatic wait_done(output int edges, output int busy_cycles);
      edges = 0;
      busy_cycles = 0;
      while (!done && edges < 40) begin
         if (busy) busy_cycles++;
         step();
         edges++;
      end
   endtask

   function automatic longint model(input longint d, input longint q, input longint r);
`ifdef SEQ_MUL_ADDEND_EN
      return d * q + r;
`else
      return d * q;
`endif
   endfunction

   // One pulsed operation from IDLE/DONE, with latency, busy, product and hold checks.
   task automatic run_op(input string tag, input longint d, input longint q, input longint r,
                         input longint exp);
      int e;
      int b;
      multiplicand = DW'(d);
      multiplier   = QW'(q);
      addend       = DW'(r);
      start        = 1'b1;
      step();
      start = 1'b0;
      wait_done(e, b);
      check_val({tag, "_latency"}, e, QW);
      check_val({tag, "_busy"}, b, QW);
      check_val({tag, "_product"}, product, exp);
      step();
      check_val({tag, "_done_drop"}, done, 0);
      check_val({tag, "_hold"}, product, exp);
   endtask

   initial begin
      int e;
      int b;
      bit seen_done;
      longint d;
      longint q;
      longint r;
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      addend       = '0;
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_product", product, 0);

      run_op("basic", 1000, 100, 0, 64'd100000);
      run_op("max", 131071, 511, 0, 64'd66977281);
`ifdef SEQ_MUL_ADDEND_EN
      run_op("max_add", 131071, 511, 131071, 64'd67108352);
      run_op("rem", 1234, 37, 500, 64'd46158);
      run_op("zero_q", 1234, 0, 7, 64'd7);
`else
      run_op("max_add", 131071, 511, 131071, 64'd66977281);
      run_op("rem", 1234, 37, 500, 64'd45658);
      run_op("zero_q", 1234, 0, 7, 64'd0);
`endif

      // start held high across three operations
      multiplicand = 17'd3;
      multiplier   = 9'd5;
      addend       = '0;
      start        = 1'b1;
      step();
      wait_done(e, b);
      check_val("b2b0_latency", e, QW);
      check_val("b2b0_product", product, 15);
      multiplicand = 17'd0;
      multiplier   = 9'd9;
      step();
      check_val("b2b1_busy", busy, 1);
      wait_done(e, b);
      check_val("b2b1_period", e + 1, QW + 1);
      check_val("b2b1_product", product, 0);
      multiplicand = 17'd65535;
      multiplier   = 9'd2;
      step();
      wait_done(e, b);
      check_val("b2b2_period", e + 1, QW + 1);
      check_val("b2b2_product", product, 131070);
      start = 1'b0;
      step();
      check_val("b2b_end_busy", busy, 0);
      check_val("b2b_end_done", done, 0);

      // start pulse with different operands mid-RUN must be ignored
      multiplicand = 17'd1000;
      multiplier   = 9'd100;
      start        = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      multiplicand = 17'd7;
      multiplier   = 9'd7;
      addend       = 17'd7;
      start        = 1'b1;
      step();
      start = 1'b0;
      wait_done(e, b);
      check_val("midstart_latency", e + 4, QW);
      check_val("midstart_product", product, 100000);
      step();
      check_val("midstart_idle", busy, 0);

      // reset asserted four cycles into RUN
      multiplicand = 17'd500;
      multiplier   = 9'd300;
      addend       = '0;
      start        = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst_n = 1'b0;
      step();
      check_val("abort_busy", busy, 0);
      check_val("abort_done", done, 0);
      check_val("abort_product", product, 0);
      step();
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (done) seen_done = 1'b1;
      end
      check_val("abort_no_done", seen_done, 0);
      check_val("abort_idle_busy", busy, 0);

      for (int i = 0; i < 200; i++) begin
         d = longint'($urandom_range(0, 131071));
         q = longint'($urandom_range(0, 511));
         r = longint'($urandom_range(0, 131071));
         run_op("rand", d, q, r, model(d, q, r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
